t03_load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the decoder.
- Consumes memRead, memWrite and dataWidth from the decoder, plus the ALU result (address) and register-file read data 2 (store data).
- Runs one registered request/acknowledge transaction per load or store on the data-memory bus.
- Stalls the core while the transaction is in flight, and returns extended load data to the write-back mux (memToReg path).

---
 rtl/t03_load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_t03_load_store_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/t03_load_store_unit.sv
// t03_load_store_unit
// Memory-access stage sitting right after the decoder. Each load or store
// becomes one registered request/acknowledge transaction on the data bus.
// The core is stalled while the transaction is in flight. Load data is
// extended and returned to the write-back mux.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   memRead, memWrite   decoder load / store strobes (store wins if both)
//   dataWidth           funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   address             byte address from the ALU
//   storeData           register-file read data 2
//   busRead, busWrite   registered bus strobes
//   busAddr             registered word-aligned address
//   busWData            registered lane-replicated store data
//   busSel              registered byte-lane enables
//   busAck, busRData    bus completion and read data (same cycle)
//   loadData            extended load result, held until the next load completes
//   stall               freeze PC/pipeline while an access is pending
//   misaligned          one-cycle pulse when a misaligned access is rejected
//   busError            one-cycle pulse when an access times out
module t03_load_store_unit #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  dataWidth,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        busRead,
  output logic        busWrite,
  output logic [31:0] busAddr,
  output logic [31:0] busWData,
  output logic [3:0]  busSel,
  input  logic        busAck,
  input  logic [31:0] busRData,
  output logic [31:0] loadData,
  output logic        stall,
  output logic        misaligned,
  output logic        busError
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // The abort fires in the REQ cycle whose increment would reach the limit,
  // so the strobe is visible for exactly TIMEOUT_CYCLES cycles.
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, nextState;

  logic [CW-1:0] timeoutCount;
  logic          isByte, isHalf, isWord, isUnsigned;
  logic          req, misalignedReq, accept, timeoutHit;
  logic [3:0]    laneSel;
  logic [31:0]   laneWData;
  logic          reqByte, reqHalf, reqUnsigned;
  logic [1:0]    reqOffset;
  logic [7:0]    byteLane;
  logic [15:0]   halfLane;
  logic [31:0]   extendedLoad;

  // Width decode; the undefined funct3 codes fall through to word accesses.
  always_comb begin
    isByte        = (dataWidth == 3'b000) || (dataWidth == 3'b100);
    isHalf        = (dataWidth == 3'b001) || (dataWidth == 3'b101);
    isWord        = !isByte && !isHalf;
    isUnsigned    = dataWidth[2];
    req           = memRead || memWrite;
    misalignedReq = (isHalf && address[0]) || (isWord && (address[1:0] != 2'b00));
    accept        = (state == IDLE) && req && !misalignedReq;
    timeoutHit    = (state == REQ) && !busAck && (timeoutCount == LAST_COUNT);
  end

  // Byte-lane enables and store-data replication for the requested width.
  always_comb begin
    laneSel   = 4'b1111;
    laneWData = storeData;
    if (isByte) begin
      laneSel   = 4'b0001 << address[1:0];
      laneWData = {4{storeData[7:0]}};
    end else if (isHalf) begin
      laneSel   = 4'b0011 << address[1:0];
      laneWData = {2{storeData[15:0]}};
    end
  end

  // Pick the addressed lane out of the returned word and extend it, using
  // the width/offset captured when the request was accepted.
  always_comb begin
    case (reqOffset)
      2'd0:    byteLane = busRData[7:0];
      2'd1:    byteLane = busRData[15:8];
      2'd2:    byteLane = busRData[23:16];
      default: byteLane = busRData[31:24];
    endcase
    halfLane     = reqOffset[1] ? busRData[31:16] : busRData[15:0];
    extendedLoad = busRData;
    if (reqByte) begin
      extendedLoad = reqUnsigned ? {24'd0, byteLane} : {{24{byteLane[7]}}, byteLane};
    end else if (reqHalf) begin
      extendedLoad = reqUnsigned ? {16'd0, halfLane} : {{16{halfLane[15]}}, halfLane};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = REQ;
      REQ:     if (busAck || timeoutHit) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Stall covers the accepting IDLE cycle and every REQ cycle; DONE drops it
  // so the core can retire. Gated by reset so it falls as soon as reset rises.
  always_comb begin
    stall = !rst && (accept || (state == REQ));
  end

  // Bus registers, timeout counter, captured request info and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busRead      <= 1'b0;
      busWrite     <= 1'b0;
      busAddr      <= '0;
      busWData     <= '0;
      busSel       <= '0;
      loadData     <= '0;
      misaligned   <= 1'b0;
      busError     <= 1'b0;
      timeoutCount <= '0;
      reqByte      <= 1'b0;
      reqHalf      <= 1'b0;
      reqUnsigned  <= 1'b0;
      reqOffset    <= '0;
    end else begin
      misaligned <= (state == IDLE) && req && misalignedReq;
      busError   <= timeoutHit;
      if (accept) begin
        busRead      <= !memWrite;
        busWrite     <= memWrite;
        busAddr      <= {address[31:2], 2'b00};
        busSel       <= laneSel;
        busWData     <= laneWData;
        reqByte      <= isByte;
        reqHalf      <= isHalf;
        reqUnsigned  <= isUnsigned;
        reqOffset    <= address[1:0];
        timeoutCount <= '0;
      end else if (state == REQ) begin
        if (busAck) begin
          busRead  <= 1'b0;
          busWrite <= 1'b0;
          if (busRead) loadData <= extendedLoad;
        end else if (timeoutHit) begin
          busRead  <= 1'b0;
          busWrite <= 1'b0;
          if (busRead) loadData <= '0;
        end else begin
          timeoutCount <= timeoutCount + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_t03_load_store_unit.sv
// tb_t03_load_store_unit
// Self-checking bench for the load/store unit, built with a short timeout so
// the abort path is reachable. Every completed access pushes its expected
// loadData/busError onto a scoreboard; a monitor pops and compares on the
// cycle stall falls (the DONE cycle).
module tb_t03_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [2:0]  dataWidth = 3'b000;
  logic [31:0] address = 32'd0;
  logic [31:0] storeData = 32'd0;
  logic        busRead, busWrite;
  logic [31:0] busAddr, busWData;
  logic [3:0]  busSel;
  logic        busAck = 1'b0;
  logic [31:0] busRData = 32'd0;
  logic [31:0] loadData;
  logic        stall, misaligned, busError;

  int testsRun = 0;
  int failCount = 0;

  typedef struct packed {
    logic [31:0] loadData;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t monExp;
  bit   prevStall = 1'b0;

  t03_load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .dataWidth  (dataWidth),
    .address    (address),
    .storeData  (storeData),
    .busRead    (busRead),
    .busWrite   (busWrite),
    .busAddr    (busAddr),
    .busWData   (busWData),
    .busSel     (busSel),
    .busAck     (busAck),
    .busRData   (busRData),
    .loadData   (loadData),
    .stall      (stall),
    .misaligned (misaligned),
    .busError   (busError)
  );

  always #5 clk = ~clk;

  // Single point of comparison: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Scoreboard consumer: the falling edge of stall marks the DONE cycle.
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall && !stall) begin
        if (sb.size() == 0) begin
          checkOutput("sbOccupancyAtDone", 32'(sb.size()), 32'd1);
        end else begin
          monExp = sb.pop_front();
          checkOutput("doneLoadData", loadData, monExp.loadData);
          checkOutput("doneBusError", 32'(busError), 32'(monExp.err));
        end
      end
      prevStall = stall;
    end
  end

  // Drives one aligned access and follows it through REQ and DONE. ackAfter is
  // the REQ-cycle index (0-based) in which busAck is raised; -1 never acks.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [2:0] w, input logic [31:0] addr,
                               input logic [31:0] sd, input logic [31:0] rdata,
                               input int ackAfter, input logic [31:0] expAddr,
                               input logic [3:0] expSel, input logic [31:0] expWData,
                               input logic [31:0] expLoad, input logic expErr,
                               input int expStall);
    exp_t e;
    int   stallCycles;
    bit   doneSeen;
    stallCycles = 0;
    doneSeen    = 1'b0;
    memRead   = rd;
    memWrite  = wr;
    dataWidth = w;
    address   = addr;
    storeData = sd;
    busRData  = rdata;
    busAck    = 1'b0;
    e.loadData = expLoad;
    e.err      = expErr;
    sb.push_back(e);
    @(negedge clk);
    checkOutput({tag, " stallReq"}, 32'(stall), 32'd1);
    checkOutput({tag, " noStrobeYet"}, 32'({busRead, busWrite}), 32'd0);
    if (stall) stallCycles++;
    @(posedge clk); #1;
    for (int c = 0; c < 50 && !doneSeen; c++) begin
      busAck = (c == ackAfter);
      @(negedge clk);
      if (c == 0) begin
        checkOutput({tag, " busAddr"}, busAddr, expAddr);
        checkOutput({tag, " busSel"}, 32'(busSel), 32'(expSel));
        checkOutput({tag, " busWData"}, busWData, expWData);
        checkOutput({tag, " busRead"}, 32'(busRead), 32'(rd && !wr));
        checkOutput({tag, " busWrite"}, 32'(busWrite), 32'(wr));
      end
      if (stall) begin
        stallCycles++;
        @(posedge clk); #1;
      end else begin
        doneSeen = 1'b1;
      end
    end
    checkOutput({tag, " doneSeen"}, 32'(doneSeen), 32'd1);
    checkOutput({tag, " stallCycles"}, 32'(stallCycles), 32'(expStall));
    checkOutput({tag, " strobesDropped"}, 32'({busRead, busWrite}), 32'd0);
    memRead  = 1'b0;
    memWrite = 1'b0;
    busAck   = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({tag, " idleStall"}, 32'(stall), 32'd0);
    checkOutput({tag, " errPulseOnce"}, 32'(busError), 32'd0);
    checkOutput({tag, " loadHeld"}, loadData, expLoad);
    @(posedge clk); #1;
  endtask

  // Misaligned request: rejected in IDLE, one misaligned pulse, no bus activity.
  task automatic applyMisaligned(input string tag, input logic [2:0] w,
                                 input logic [31:0] addr, input logic [31:0] heldLoad);
    memRead   = 1'b1;
    memWrite  = 1'b0;
    dataWidth = w;
    address   = addr;
    @(negedge clk);
    checkOutput({tag, " noStall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    memRead = 1'b0;
    @(negedge clk);
    checkOutput({tag, " misPulse"}, 32'(misaligned), 32'd1);
    checkOutput({tag, " noStrobe"}, 32'({busRead, busWrite}), 32'd0);
    checkOutput({tag, " stallLow"}, 32'(stall), 32'd0);
    checkOutput({tag, " loadKept"}, loadData, heldLoad);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({tag, " misOnce"}, 32'(misaligned), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst strobes", 32'({busRead, busWrite}), 32'd0);
    checkOutput("rst busAddr", busAddr, 32'd0);
    checkOutput("rst busSel", 32'(busSel), 32'd0);
    checkOutput("rst busWData", busWData, 32'd0);
    checkOutput("rst loadData", loadData, 32'd0);
    checkOutput("rst flags", 32'({stall, misaligned, busError}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    //            tag    rd   wr   w       addr          sd            rdata         ack busAddr       sel      wdata         load          err  stall
    applyStimulus("LB",  1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0, 3);
    applyStimulus("LBU", 1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1, 32'h0000_1000, 4'b1000, 32'h0,        32'h0000_0080, 1'b0, 3);
    applyStimulus("SH",  1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0080, 1'b0, 2);
    applyStimulus("LW",  1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0,        32'h1234_5678, 0, 32'h0000_0040, 4'b1111, 32'h0,        32'h1234_5678, 1'b0, 2);
    applyStimulus("LH",  1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 2, 32'h0000_0000, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0, 4);
    applyStimulus("LHU", 1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 0, 32'h0000_0000, 4'b1100, 32'h0,        32'h0000_8001, 1'b0, 2);
    applyStimulus("SBprio", 1'b1, 1'b1, 3'b000, 32'h0000_0005, 32'h1234_56A5, 32'h7777_7777, 0, 32'h0000_0004, 4'b0010, 32'hA5A5_A5A5, 32'h0000_8001, 1'b0, 2);
    applyStimulus("LWbadWidth", 1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 1, 32'h0000_0100, 4'b1111, 32'h0,      32'hCAFE_F00D, 1'b0, 3);

    applyMisaligned("misLW", 3'b010, 32'h0000_0041, 32'hCAFE_F00D);
    applyMisaligned("misLH", 3'b001, 32'h0000_0043, 32'hCAFE_F00D);
    applyMisaligned("misBadWidth", 3'b110, 32'h0000_0002, 32'hCAFE_F00D);

    applyStimulus("timeout", 1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0, 32'h5555_5555, -1, 32'h0000_0080, 4'b1111, 32'h0, 32'h0, 1'b1, 5);
    applyStimulus("LWpre", 1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h1122_3344, 1, 32'h0000_0044, 4'b1111, 32'h0, 32'h1122_3344, 1'b0, 3);

    // Stray acknowledge while idle must not touch loadData.
    busAck   = 1'b1;
    busRData = 32'hDEAD_DEAD;
    @(negedge clk);
    checkOutput("strayAck stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    busAck = 1'b0;
    @(negedge clk);
    checkOutput("strayAck loadData", loadData, 32'h1122_3344);
    @(posedge clk); #1;

    // Reset while a load is waiting in REQ.
    memRead   = 1'b1;
    dataWidth = 3'b010;
    address   = 32'h0000_0080;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midRst busReadBefore", 32'(busRead), 32'd1);
    checkOutput("midRst stallBefore", 32'(stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRst busReadDrop", 32'(busRead), 32'd0);
    checkOutput("midRst stallDrop", 32'(stall), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    memRead = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    checkOutput("midRst idleStall", 32'(stall), 32'd0);
    checkOutput("midRst idleBus", 32'({busRead, busWrite}), 32'd0);
    checkOutput("midRst loadData", loadData, 32'd0);
    @(posedge clk); #1;

    applyStimulus("LBUpostRst", 1'b1, 1'b0, 3'b100, 32'h0000_0000, 32'h0, 32'h0BAD_CAFE, 0, 32'h0000_0000, 4'b0001, 32'h0, 32'h0000_00FE, 1'b0, 2);

    checkOutput("sbDrained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
